// File: rtl/platform_rom_arbiter_pkg.sv
// Shared constants and types for the program-memory arbiter.
package platform_rom_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Requester indices: instruction master and data master
  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Read-response tag travelling alongside the memory read latency
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/platform_rom_arbiter_rr_arb2.sv
// Two-way round-robin grant; pointer names the side that wins a tie.
module platform_rom_arbiter_rr_arb2
  import platform_rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer update; pointer moves to the loser after any grant
  always_comb begin
    gnt_c = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = (ptr_q == REQ_DATA) ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
      if (gnt_c != 2'b00) begin
        ptr_d = gnt_c[0] ? REQ_DATA : REQ_INSTR;
      end
    end
  end

  // Pointer register, instruction master favoured out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= REQ_INSTR;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/platform_rom_arbiter.sv
// Two-requester arbiter sharing the single-port program memory.
module platform_rom_arbiter
  import platform_rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic [DATA_W-1:0]   r0_writedata,
  input  logic                r0_debugaccess,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic [DATA_W-1:0]   r1_writedata,
  input  logic                r1_debugaccess,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_debugaccess,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                wr_viol,
  output logic                busy
);

  logic              en_c;
  logic [1:0]        req_c;
  logic [1:0]        gnt_c;
  logic              granted_c;
  logic              sel_c;
  logic              w_rd_c;
  logic              w_wr_c;
  logic              w_dbg_c;
  logic              viol_c;
  logic              rdv0_c;
  logic              rdv1_c;
  tag_t              tail_c;
  tag_t              tags_q [RD_LAT];
  tag_t              tags_d [RD_LAT];
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata0_d;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata1_d;
  logic              busy_q;
  logic              busy_d;
  logic              wr_viol_q;
  logic              wr_viol_d;

  assign en_c      = ~reset & ~reset_req;
  assign req_c     = {r1_read | r1_write, r0_read | r0_write};
  assign mem_clken = 1'b1;

  platform_rom_arbiter_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (en_c),
    .req   (req_c),
    .gnt_c (gnt_c)
  );

  // Winner's command onto the memory port; writes lacking debugaccess are swallowed
  always_comb begin
    granted_c       = |gnt_c;
    sel_c           = gnt_c[REQ_DATA];
    w_rd_c          = sel_c ? r1_read        : r0_read;
    w_wr_c          = sel_c ? r1_write       : r0_write;
    w_dbg_c         = sel_c ? r1_debugaccess : r0_debugaccess;
    mem_address     = sel_c ? r1_address     : r0_address;
    mem_byteenable  = sel_c ? r1_byteenable  : r0_byteenable;
    mem_writedata   = sel_c ? r1_writedata   : r0_writedata;
    mem_chipselect  = granted_c & (w_rd_c | (w_wr_c & w_dbg_c));
    mem_write       = granted_c & ~w_rd_c & w_wr_c & w_dbg_c;
    mem_debugaccess = granted_c & w_dbg_c;
    viol_c          = granted_c & ~w_rd_c & w_wr_c & ~w_dbg_c;
    r0_waitrequest  = ~en_c | (req_c[REQ_INSTR] & ~gnt_c[REQ_INSTR]);
    r1_waitrequest  = ~en_c | (req_c[REQ_DATA]  & ~gnt_c[REQ_DATA]);
  end

  // Tag pipe advance, response steering and held read data
  always_comb begin
    tags_d[0].valid = granted_c & w_rd_c;
    tags_d[0].owner = sel_c;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tags_d[i] = tags_q[i-1];
    end
    tail_c   = tags_q[RD_LAT-1];
    rdv0_c   = ~reset & tail_c.valid & (tail_c.owner == REQ_INSTR);
    rdv1_c   = ~reset & tail_c.valid & (tail_c.owner == REQ_DATA);
    rdata0_d = rdv0_c ? mem_readdata : rdata0_q;
    rdata1_d = rdv1_c ? mem_readdata : rdata1_q;
    busy_d   = 1'b0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      busy_d = busy_d | tags_d[i].valid;
    end
    wr_viol_d = wr_viol_q | viol_c;
  end

  assign r0_readdatavalid = rdv0_c;
  assign r1_readdatavalid = rdv1_c;
  assign r0_readdata      = rdata0_d;
  assign r1_readdata      = rdata1_d;
  assign busy             = busy_q;
  assign wr_viol          = wr_viol_q;

  // State registers; reset discards in-flight tags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tags_q[i] <= '0;
      end
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
      wr_viol_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tags_q[i] <= tags_d[i];
      end
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
      wr_viol_q <= wr_viol_d;
    end
  end

  // Read and write asserted together is a requester protocol error
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r0_rw_excl: assert (!(r0_read && r0_write));
      a_r1_rw_excl: assert (!(r1_read && r1_write));
    end
  end

endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Bench for platform_rom_arbiter with an attached 1024x32 program memory.
module tb_platform_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [9:0]  r0_address, r1_address;
  logic        r0_read, r0_write, r0_debugaccess;
  logic        r1_read, r1_write, r1_debugaccess;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        wr_viol, busy;

  always #5 clk = ~clk;

  platform_rom_arbiter dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_byteenable(r0_byteenable), .r0_writedata(r0_writedata),
    .r0_debugaccess(r0_debugaccess), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_byteenable(r1_byteenable), .r1_writedata(r1_writedata),
    .r1_debugaccess(r1_debugaccess), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .wr_viol(wr_viol), .busy(busy)
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  // Program memory: registered address, unregistered q
  logic [31:0] ram [1024];
  logic [9:0]  ram_addr_q = '0;
  logic        ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 1024; a++) ram[a] <= init_val(a);
    end else if (mem_clken && mem_chipselect) begin
      ram_addr_q <= mem_address;
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
    end
  end

  assign mem_readdata = ram[ram_addr_q];

  // Reference state: expected memory image, pending responses, tie-break side
  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          prio = 0;
  bit          wr_viol_exp = 1'b0;
  logic [31:0] exp_mem [1024];
  rsp_t        rq [$];
  logic [31:0] hold_exp [2];
  bit          hold_known [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drv(input int i, input bit rd, input bit wr, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] be, input bit dbg);
    if (i == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a;
      r0_writedata = d; r0_byteenable = be; r0_debugaccess = dbg;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a;
      r1_writedata = d; r1_byteenable = be; r1_debugaccess = dbg;
    end
  endtask

  task automatic idle(input int i);
    drv(i, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic rand_cmd(input int i);
    int unsigned kind;
    kind = $urandom_range(0, 5);
    if (kind < 2) idle(i);
    else drv(i, kind != 5, kind == 5, 10'($urandom_range(0, 15)), 32'($urandom),
             4'($urandom_range(1, 15)), $urandom_range(0, 3) != 0);
  endtask

  // One clock: predict from the rules, compare mid-cycle, then advance the reference
  task automatic run_cycle(output int w);
    bit          rd [2], wr [2], dbg [2], act [2], wt [2], rdv [2];
    logic [9:0]  ad [2];
    logic [31:0] wd [2], rdat [2];
    logic [3:0]  be [2];
    bit          stalled, due, e_cs, e_mw, e_rdv;
    @(negedge clk);
    rd[0] = r0_read; wr[0] = r0_write; dbg[0] = r0_debugaccess; ad[0] = r0_address;
    wd[0] = r0_writedata; be[0] = r0_byteenable;
    rd[1] = r1_read; wr[1] = r1_write; dbg[1] = r1_debugaccess; ad[1] = r1_address;
    wd[1] = r1_writedata; be[1] = r1_byteenable;
    wt[0] = r0_waitrequest; wt[1] = r1_waitrequest;
    rdv[0] = r0_readdatavalid; rdv[1] = r1_readdatavalid;
    rdat[0] = r0_readdata; rdat[1] = r1_readdata;
    for (int i = 0; i < 2; i++) act[i] = rd[i] | wr[i];
    stalled = reset | reset_req;
    w = -1;
    if (!stalled) begin
      if (act[0] && act[1]) w = prio;
      else if (act[0]) w = 0;
      else if (act[1]) w = 1;
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("waitrequest%0d", i), 32'(wt[i]), 32'(stalled || (act[i] && w != i)));
    e_cs = 1'b0; e_mw = 1'b0;
    if (w >= 0) begin
      if (rd[w]) e_cs = 1'b1;
      else begin e_cs = dbg[w]; e_mw = dbg[w]; end
    end
    chk("mem_chipselect", 32'(mem_chipselect), 32'(e_cs));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    if (e_cs) begin
      chk("mem_address", 32'(mem_address), 32'(ad[w]));
      chk("mem_debugaccess", 32'(mem_debugaccess), 32'(dbg[w]));
    end
    if (e_mw) begin
      chk("mem_writedata", mem_writedata, wd[w]);
      chk("mem_byteenable", 32'(mem_byteenable), 32'(be[w]));
    end
    due = !reset && rq.size() > 0 && rq[0].due == cyc;
    for (int i = 0; i < 2; i++) begin
      e_rdv = due && rq[0].owner == i;
      chk($sformatf("readdatavalid%0d", i), 32'(rdv[i]), 32'(e_rdv));
      if (e_rdv) chk($sformatf("readdata%0d", i), rdat[i], rq[0].data);
      else if (hold_known[i]) chk($sformatf("readdata_hold%0d", i), rdat[i], hold_exp[i]);
    end
    if (!reset) begin
      chk("busy", 32'(busy), 32'(due));
      chk("wr_viol", 32'(wr_viol), 32'(wr_viol_exp));
    end
    if (reset) begin
      rq.delete();
      prio = 0;
      wr_viol_exp = 1'b0;
      hold_known[0] = 1'b0; hold_known[1] = 1'b0;
    end else begin
      if (due) begin
        hold_exp[rq[0].owner] = rq[0].data;
        hold_known[rq[0].owner] = 1'b1;
        void'(rq.pop_front());
      end
      if (w >= 0) begin
        if (rd[w]) rq.push_back('{due: cyc + 1, owner: w, data: exp_mem[ad[w]]});
        else if (dbg[w]) begin
          for (int b = 0; b < 4; b++)
            if (be[w][b]) exp_mem[ad[w]][b*8 +: 8] = wd[w][b*8 +: 8];
        end else wr_viol_exp = 1'b1;
        prio = 1 - w;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int         w;
    logic [9:0] a0, a1;
    for (int a = 0; a < 1024; a++) exp_mem[a] = init_val(a);
    hold_known[0] = 1'b0; hold_known[1] = 1'b0;
    ram_init = 1'b1; reset = 1'b1; reset_req = 1'b0;
    idle(0); idle(1);

    // Reset
    run_cycle(w);
    ram_init = 1'b0;
    run_cycle(w);
    chk("mem_clken", 32'(mem_clken), 32'd1);
    reset = 1'b0;

    // Both read continuously: strict alternation starting with r0
    a0 = 10'h000; a1 = 10'h200;
    for (int k = 0; k < 8; k++) begin
      drv(0, 1'b1, 1'b0, a0, 32'h0, 4'hF, 1'b0);
      drv(1, 1'b1, 1'b0, a1, 32'h0, 4'hF, 1'b0);
      run_cycle(w);
      if (w == 0) a0++;
      else if (w == 1) a1++;
    end
    idle(0); idle(1);
    run_cycle(w);

    // r0 alone, back-to-back reads
    drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'hF, 1'b0); run_cycle(w);
    drv(0, 1'b1, 1'b0, 10'h011, 32'h0, 4'hF, 1'b0); run_cycle(w);
    idle(0); run_cycle(w); run_cycle(w);

    // Debug write then readback
    drv(1, 1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF, 4'hF, 1'b1); run_cycle(w);
    drv(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 1'b0); run_cycle(w);
    idle(1); run_cycle(w);
    chk("readback_dbg_write", r1_readdata, 32'hDEADBEEF);
    chk("wr_viol_clear", 32'(wr_viol), 32'd0);

    // Non-debug write is dropped and flagged
    drv(1, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 4'hF, 1'b0); run_cycle(w);
    drv(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 1'b0); run_cycle(w);
    idle(1); run_cycle(w);
    chk("readback_dropped_write", r1_readdata, 32'hDEADBEEF);
    chk("wr_viol_set", 32'(wr_viol), 32'd1);

    // reset_req after an accepted read: drain, stall, resume
    drv(0, 1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0); run_cycle(w);
    reset_req = 1'b1;
    drv(0, 1'b1, 1'b0, 10'h021, 32'h0, 4'hF, 1'b0);
    drv(1, 1'b1, 1'b0, 10'h201, 32'h0, 4'hF, 1'b0);
    repeat (3) run_cycle(w);
    reset_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_cycle(w);
      if (w >= 0) idle(w);
    end
    chk("wr_viol_sticky", 32'(wr_viol), 32'd1);

    // Reset right after an accepted read
    drv(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'hF, 1'b0); run_cycle(w);
    idle(0); reset = 1'b1; run_cycle(w);
    reset = 1'b0;
    drv(0, 1'b1, 1'b0, 10'h040, 32'h0, 4'hF, 1'b0);
    drv(1, 1'b1, 1'b0, 10'h240, 32'h0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(w);
      if (w >= 0) idle(w);
    end

    // Random traffic with occasional reset_req
    for (int k = 0; k < 400; k++) begin
      reset_req = ($urandom_range(0, 19) == 0);
      run_cycle(w);
      for (int i = 0; i < 2; i++) begin
        if (w == i || !((i == 0) ? (r0_read | r0_write) : (r1_read | r1_write))
            || $urandom_range(0, 15) == 0)
          rand_cmd(i);
      end
    end
    reset_req = 1'b0;
    idle(0); idle(1);
    repeat (3) run_cycle(w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_rom_arbiter.md
Name: platform_rom_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single-port 1024x32 on-chip program memory: address register inside the RAM, unregistered q, so read data arrives 1 clk after the accepted command.
- Shares the single port between the CPU instruction master (req 0) and data master (req 1) using fair round-robin.
- Pipelined: up to one command accepted per cycle, with read-data steering to the owning requester.
- Also enforces the debug-only write rule and honours reset_req by draining before halting.

Parameters:
- ADDR_W, 10, word address width of memory
- DATA_W, 32, data width; byteenable width = DATA_W/8
- RD_LAT, 1, cycles from accepted read to memory q valid (1..4)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset-request; stop accepting, drain in-flight reads
- rN_address  in  ADDR_W  requester N word address (N = 0,1; same set for each)
- rN_read  in  1  read command
- rN_write  in  1  write command
- rN_byteenable  in  DATA_W/8  byte lanes
- rN_writedata  in  DATA_W  write data
- rN_debugaccess  in  1  debug-mode qualifier
- rN_waitrequest  out  1  command not accepted this cycle
- rN_readdata  out  DATA_W  read data
- rN_readdatavalid  out  1  rN_readdata valid
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  DATA_W/8  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_debugaccess  out  1  to memory
- mem_clken  out  1  memory clock enable, constant 1
- mem_readdata  in  DATA_W  memory q
- wr_viol  out  1  sticky: a write without debugaccess was dropped
- busy  out  1  any read in flight

Behaviour:
Reset values (synchronous reset):
- rN_waitrequest=1 while reset high.
- readdatavalid=0.
- mem_chipselect=0, mem_write=0.
- Round-robin pointer = req 0 has priority.
- Pipeline tags cleared; wr_viol=0; busy=0.

Request and grant:
- A request is rN_read|rN_write. Read and write both high is illegal: treat as read, and flag in an assertion.
- Combinational grant each cycle when not stalled. If only one requester is active it wins. If both are active, the pointer side wins.
- After any grant, the pointer moves to the non-granted requester.
- Winner: waitrequest=0, and its command is driven onto mem_* in the same cycle (combinational mux, mem_chipselect=1).
- Loser: waitrequest=1, and must hold its command stable.
- Idle requester: waitrequest=0, which is harmless since no command is issued.

Writes:
- mem_write=1 only if rN_debugaccess=1; mem_debugaccess mirrors the winner's debugaccess.
- A write without debugaccess is still accepted (waitrequest=0) but mem_write is forced 0 and mem_chipselect=0. wr_viol is set and stays set until reset.
- Writes produce no readdatavalid.

Reads:
- RD_LAT-deep shift register of {valid, owner} tags.
- Exactly RD_LAT cycles after acceptance, the owner gets readdatavalid=1 and readdata=mem_readdata. The other requester's readdata holds its last value.
- Back-to-back reads from alternating requesters sustain 1 read per cycle, and responses return in acceptance order.

reset_req:
- While high: both waitrequest=1 and no new mem command.
- Tags already in flight still complete. busy falls once the tag pipe is empty.
- The pointer is frozen.
- On deassertion, arbitration resumes the next cycle.

Edge cases:
- Reset asserted mid-read: in-flight tags are discarded and no readdatavalid follows.
- Requester drops its request while waiting: allowed, and no grant is issued for it.

Decomposition:
- Shared package holds requester-index constants (REQ_INSTR=0, REQ_DATA=1) and the tag struct {valid, owner}.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a pointer register.
- Tag pipe and muxes stay in the top level.

Test Plan:
- Only r0 reads addr 0x010, then 0x011 on consecutive cycles -> waitrequest=0 both cycles; r0_readdatavalid at T+1 and T+2 with mem contents; r1_readdatavalid never asserted.
- r0 and r1 both read continuously (r0 0x000.., r1 0x200..) -> grants alternate r0,r1,r0,r1 starting with r0 after reset; each data returns to its owner 1 cycle later; no bubbles.
- r1 writes 0xDEADBEEF to 0x3FF with debugaccess=1, byteenable=0xF, then reads 0x3FF -> readback 0xDEADBEEF; wr_viol=0.
- r1 writes 0x12345678 to 0x3FF with debugaccess=0 -> accepted, mem_write=0, wr_viol=1 and sticky; readback still 0xDEADBEEF.
- r0 read accepted, reset_req raised the next cycle -> read data still delivered; waitrequest=1 for both while reset_req is high; busy falls 1 cycle after the last tag; arbitration resumes the cycle after reset_req drops.
- Reset asserted on the cycle after a read is accepted -> no readdatavalid; all outputs at reset values; next grant goes to r0.
